// File: rtl/host_readout_pkg.sv
// Shared constants, FSM state type and helpers for the host readback responder.
package host_readout_pkg;

  localparam int N_CELLS    = 2500;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 16;
  localparam int REQ_WIDTH  = 16;
  localparam int IDX_WIDTH  = 15;

  // Readback FSM states; the numeric encoding is visible on dbg_state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  // True when a host pixel index addresses a real lattice cell.
  function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx);
    return idx < IDX_WIDTH'(N_CELLS);
  endfunction

endpackage

// File: rtl/host_readout_gpio_req_detect.sv
// Registers the host request word and flags new requests. A request is new
// when host_transmission rises, or when it is held high while the index
// changes. The flag is registered so it lines up with the registered index.
module host_readout_gpio_req_detect
  import host_readout_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_WIDTH-1:0] req_word,
  output logic                 new_req,
  output logic                 req_active,
  output logic [IDX_WIDTH-1:0] req_index
);

  logic [REQ_WIDTH-1:0] req_q;
  logic                 new_req_r;
  logic                 detect;

  // Compare the live word with last cycle's copy to spot a fresh request.
  always_comb begin
    detect = 1'b0;
    if (req_word[REQ_WIDTH-1]) begin
      detect = !req_q[REQ_WIDTH-1] ||
               (req_word[IDX_WIDTH-1:0] != req_q[IDX_WIDTH-1:0]);
    end
  end

  // Request stage: copy the GPIO word every cycle and register the new flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      new_req_r <= 1'b0;
    end else begin
      req_q     <= req_word;
      new_req_r <= detect;
    end
  end

  assign new_req    = new_req_r;
  assign req_active = req_q[REQ_WIDTH-1];
  assign req_index  = req_q[IDX_WIDTH-1:0];

endmodule

// File: rtl/host_readout.sv
// Host readback responder: serves one pixel of the macroscopic field (u_x,
// u_y, rho, u^2) to the GPIO block, only reading the field RAMs while the
// solver is outside its collision phase.
//
// Handshake: there is no ready. The host raises GPIOi[15] with an index and
// keeps it stable; GPIOvalid=1 means the held outputs belong to the index
// currently on GPIOi. Dropping GPIOi[15] or changing the index withdraws the
// request, clears GPIOvalid, and cancels any read in flight.
module host_readout
  import host_readout_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQ_WIDTH-1:0]  GPIOi,
  input  logic                  in_collision_state,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] ux_q,
  input  logic [DATA_WIDTH-1:0] uy_q,
  input  logic [DATA_WIDTH-1:0] rho_q,
  input  logic [DATA_WIDTH-1:0] u2_q,
  output logic [DATA_WIDTH-1:0] GPIOux,
  output logic [DATA_WIDTH-1:0] GPIOuy,
  output logic [DATA_WIDTH-1:0] GPIOrho,
  output logic [DATA_WIDTH-1:0] GPIOu2,
  output logic                  GPIOvalid,
  output logic                  GPIOerr,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  logic                 new_req;
  logic                 req_active;
  logic [IDX_WIDTH-1:0] req_index;

  state_t               state;
  state_t               state_next;
  logic [IDX_WIDTH-1:0] idx_r;
  logic [IDX_WIDTH-1:0] idx_next;
  logic                 err_r;
  logic                 err_next;
  logic                 clear_valid;
  logic                 clear_err;
  logic                 do_capture;

  // RAM data is only guaranteed for one cycle, so it is parked here in WAIT.
  logic [DATA_WIDTH-1:0] ux_h;
  logic [DATA_WIDTH-1:0] uy_h;
  logic [DATA_WIDTH-1:0] rho_h;
  logic [DATA_WIDTH-1:0] u2_h;

  host_readout_gpio_req_detect u_gpio_req_detect (
    .clk        (clk),
    .rst        (rst),
    .req_word   (GPIOi),
    .new_req    (new_req),
    .req_active (req_active),
    .req_index  (req_index)
  );

  // Next state: a withdrawn request aborts, a new request restarts the
  // sequence from the IDLE decision, otherwise the read walks forward.
  always_comb begin
    state_next  = state;
    idx_next    = idx_r;
    err_next    = err_r;
    clear_valid = 1'b0;
    clear_err   = 1'b0;
    do_capture  = 1'b0;
    if (!req_active) begin
      state_next  = ST_IDLE;
      clear_valid = 1'b1;
    end else if (new_req) begin
      idx_next    = req_index;
      clear_valid = 1'b1;
      clear_err   = 1'b1;
      if (!idx_in_range(req_index)) begin
        err_next   = 1'b1;
        state_next = ST_CAPTURE;
      end else begin
        err_next   = 1'b0;
        state_next = in_collision_state ? ST_HOLD : ST_ISSUE;
      end
    end else begin
      case (state)
        ST_IDLE:    state_next = ST_IDLE;
        ST_HOLD:    if (!in_collision_state) state_next = ST_ISSUE;
        ST_ISSUE:   state_next = ST_WAIT;
        ST_WAIT:    state_next = ST_CAPTURE;
        ST_CAPTURE: begin
          do_capture = 1'b1;
          state_next = ST_IDLE;
        end
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // State register plus the latched index and its out-of-range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_next;
      idx_r <= idx_next;
      err_r <= err_next;
    end
  end

  // RAM port: the strobe is high exactly while the FSM sits in ISSUE and the
  // address is loaded on entry to ISSUE, then left alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= (state_next == ST_ISSUE);
      if (state_next == ST_ISSUE) begin
        rd_addr <= idx_next[ADDR_WIDTH-1:0];
      end
    end
  end

  // Park RAM read data during WAIT, the cycle it is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ux_h  <= '0;
      uy_h  <= '0;
      rho_h <= '0;
      u2_h  <= '0;
    end else if (state == ST_WAIT) begin
      ux_h  <= ux_q;
      uy_h  <= uy_q;
      rho_h <= rho_q;
      u2_h  <= u2_q;
    end
  end

  // GPIO outputs: cleared flags on withdraw/restart, loaded on capture.
  // Values are kept after a withdraw so the host can still read them.
  always_ff @(posedge clk) begin
    if (rst) begin
      GPIOux    <= '0;
      GPIOuy    <= '0;
      GPIOrho   <= '0;
      GPIOu2    <= '0;
      GPIOvalid <= 1'b0;
      GPIOerr   <= 1'b0;
    end else begin
      if (clear_valid) GPIOvalid <= 1'b0;
      if (clear_err)   GPIOerr   <= 1'b0;
      if (do_capture) begin
        GPIOvalid <= 1'b1;
        if (err_r) begin
          GPIOux  <= '0;
          GPIOuy  <= '0;
          GPIOrho <= '0;
          GPIOu2  <= '0;
          GPIOerr <= 1'b1;
        end else begin
          GPIOux  <= ux_h;
          GPIOuy  <= uy_h;
          GPIOrho <= rho_h;
          GPIOu2  <= u2_h;
          GPIOerr <= 1'b0;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_host_readout.sv
// Directed bench for host_readout: a table of single-request transactions
// with hand-computed results, then hand-written abort/restart/reset sequences.
module tb_host_readout;
  import host_readout_pkg::*;

  typedef struct {
    logic [15:0] req;
    int          coll;
    int          lat;
    logic        err;
    logic [63:0] data;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] gpio_i;
  logic        in_coll;
  logic [11:0] rd_addr;
  logic        rd_en;
  logic [15:0] ux_q, uy_q, rho_q, u2_q;
  logic [15:0] GPIOux, GPIOuy, GPIOrho, GPIOu2;
  logic        GPIOvalid, GPIOerr, busy;
  logic [2:0]  dbg_state;

  logic [63:0] ram_q = 64'd0;
  int          rd_cnt = 0;
  int          coll_viol = 0;
  logic [11:0] last_addr = 12'd0;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  vec_t        vecs[6];

  host_readout dut (
    .clk                (clk),
    .rst                (rst),
    .GPIOi              (gpio_i),
    .in_collision_state (in_coll),
    .rd_addr            (rd_addr),
    .rd_en              (rd_en),
    .ux_q               (ux_q),
    .uy_q               (uy_q),
    .rho_q              (rho_q),
    .u2_q               (u2_q),
    .GPIOux             (GPIOux),
    .GPIOuy             (GPIOuy),
    .GPIOrho            (GPIOrho),
    .GPIOu2             (GPIOu2),
    .GPIOvalid          (GPIOvalid),
    .GPIOerr            (GPIOerr),
    .busy               (busy),
    .dbg_state          (dbg_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Field RAM contents {ux, uy, rho, u2}
  function automatic logic [63:0] ram_entry(input logic [11:0] a);
    case (a)
      12'd0:    return {16'h000A, 16'h000B, 16'h000C, 16'h000D};
      12'd3:    return {16'h0333, 16'h0334, 16'h0335, 16'h0336};
      12'd5:    return {16'h0100, 16'hFF00, 16'h1000, 16'h0010};
      12'd7:    return {16'h1234, 16'h8001, 16'h7FFF, 16'h0042};
      12'd9:    return {16'h0999, 16'h099A, 16'h099B, 16'h099C};
      12'd2499: return {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF};
      default:  return {4'h0, a, 4'hF, ~a, 4'h5, a, 2'b00, a, 2'b00};
    endcase
  endfunction

  // Synchronous RAM model: data valid only the cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) ram_q <= ram_entry(rd_addr);
    else       ram_q <= 64'hDEAD_BEEF_BAD0_F00D;
  end
  assign {ux_q, uy_q, rho_q, u2_q} = ram_q;

  // Read-port monitor
  always @(posedge clk) begin
    if (rd_en) begin
      rd_cnt    <= rd_cnt + 1;
      last_addr <= rd_addr;
      if (in_coll) coll_viol <= coll_viol + 1;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] out_word();
    return {GPIOux, GPIOuy, GPIOrho, GPIOu2};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for GPIOvalid, dropping collision after coll_len cycles; returns edges after sampling edge
  task automatic wait_valid(input int coll_len, output int lat, output bit seen);
    int n;
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (n == coll_len + 1) in_coll = 1'b0;
      if (GPIOvalid) seen = 1;
    end
    lat = n - 1;
  endtask

  initial begin
    int          lat;
    bit          seen;
    int          rd0;
    int          cv0;
    logic [63:0] w;
    vec_t        v;

    vecs[0] = '{16'h8005, 0,  4,  1'b0, {16'h0100, 16'hFF00, 16'h1000, 16'h0010}};
    vecs[1] = '{16'h8007, 10, 14, 1'b0, {16'h1234, 16'h8001, 16'h7FFF, 16'h0042}};
    vecs[2] = '{16'h89C4, 0,  2,  1'b1, 64'd0};
    vecs[3] = '{16'h8000, 0,  4,  1'b0, {16'h000A, 16'h000B, 16'h000C, 16'h000D}};
    vecs[4] = '{16'h89C3, 3,  7,  1'b0, {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF}};
    vecs[5] = '{16'hFFFF, 2,  2,  1'b1, 64'd0};

    rst     = 1'b1;
    gpio_i  = 16'h0000;
    in_coll = 1'b0;
    repeat (3) tick();
    check("reset_outputs", out_word(), 64'd0);
    check("reset_flags", {60'd0, GPIOvalid, GPIOerr, busy, rd_en}, 64'd0);
    check("reset_rd_addr", {52'd0, rd_addr}, 64'd0);
    check("reset_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    rst = 1'b0;
    repeat (2) tick();
    check("idle_after_reset", {62'd0, GPIOvalid, busy}, 64'd0);

    // Table-driven single requests
    for (int i = 0; i < 6; i++) begin
      v   = vecs[i];
      rd0 = rd_cnt;
      cv0 = coll_viol;
      if (!v.err) exp_q.push_back(v.data);
      in_coll = (v.coll > 0);
      gpio_i  = v.req;
      wait_valid(v.coll, lat, seen);
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL vec%0d_timeout: got no GPIOvalid required GPIOvalid=1", i);
      end else begin
        check($sformatf("vec%0d_latency", i), 64'(lat), 64'(v.lat));
        check($sformatf("vec%0d_err", i), {63'd0, GPIOerr}, {63'd0, v.err});
        if (v.err) check($sformatf("vec%0d_data", i), out_word(), 64'd0);
        else if (exp_q.size() > 0) check($sformatf("vec%0d_data", i), out_word(), exp_q.pop_front());
        check($sformatf("vec%0d_rd_count", i), 64'(rd_cnt - rd0), v.err ? 64'd0 : 64'd1);
        if (!v.err) check($sformatf("vec%0d_rd_addr", i), {52'd0, last_addr}, {52'd0, v.req[11:0]});
        check($sformatf("vec%0d_coll_reads", i), 64'(coll_viol - cv0), 64'd0);
      end
      gpio_i  = 16'h0000;
      in_coll = 1'b0;
      repeat (3) tick();
    end

    // Index changes 3 -> 9 while the read of 3 is in WAIT
    rd0    = rd_cnt;
    gpio_i = 16'h8003;
    repeat (3) tick();
    check("restart_in_wait_state", {61'd0, dbg_state}, {61'd0, ST_WAIT});
    gpio_i = 16'h8009;
    exp_q.push_back(ram_entry(12'd9));
    wait_valid(0, lat, seen);
    check("restart_seen_valid", {63'd0, seen}, 64'd1);
    check("restart_latency", 64'(lat), 64'd4);
    if (exp_q.size() > 0) check("restart_data_is_9", out_word(), exp_q.pop_front());
    check("restart_rd_count", 64'(rd_cnt - rd0), 64'd2);
    check("restart_rd_addr", {52'd0, last_addr}, 64'd9);

    // Host drops transmission after valid: valid clears, values retained
    w      = out_word();
    gpio_i = 16'h0000;
    repeat (2) tick();
    check("drop_valid_clear", {63'd0, GPIOvalid}, 64'd0);
    check("drop_values_kept", w, ram_entry(12'd9));
    check("drop_not_busy", {63'd0, busy}, 64'd0);

    // Back-to-back: index change with transmission held high
    gpio_i = 16'h8005;
    wait_valid(0, lat, seen);
    check("b2b_first_latency", 64'(lat), 64'd4);
    gpio_i = 16'h8007;
    repeat (2) tick();
    check("b2b_valid_drops", {63'd0, GPIOvalid}, 64'd0);
    wait_valid(0, lat, seen);
    check("b2b_second_latency", 64'(lat + 2), 64'd4);
    check("b2b_second_data", out_word(), ram_entry(12'd7));
    gpio_i = 16'h0000;
    repeat (3) tick();

    // Reset pulsed during WAIT: everything back to reset values, no capture
    gpio_i = 16'h8005;
    repeat (3) tick();
    check("rst_mid_in_wait", {61'd0, dbg_state}, {61'd0, ST_WAIT});
    rst    = 1'b1;
    gpio_i = 16'h0000;
    tick();
    check("rst_mid_outputs", out_word(), 64'd0);
    check("rst_mid_flags", {60'd0, GPIOvalid, GPIOerr, busy, rd_en}, 64'd0);
    check("rst_mid_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    check("rst_mid_rd_addr", {52'd0, rd_addr}, 64'd0);
    rst = 1'b0;
    repeat (6) tick();
    check("rst_mid_no_capture", {out_word(), 63'd0, GPIOvalid} == 127'd0 ? 64'd0 : 64'd1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
